// File: rtl/fp32_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_div_pkg
//  Description : Shared fp32 definitions for the divider: field widths,
//                exponent bias, canonical NaN and infinity encodings,
//                operand classification helpers and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_div_pkg;

    localparam int          c_fp32_exp_w  = 8;
    localparam int          c_fp32_frac_w = 23;
    localparam logic [7:0]  c_fp32_bias   = 8'd127;
    localparam logic [31:0] c_fp32_nan    = 32'h7FC0_0000;
    localparam logic [31:0] c_fp32_pinf   = 32'h7F80_0000;
    localparam logic [31:0] c_fp32_ninf   = 32'hFF80_0000;

    // Quotient bits produced: 24 mantissa (hidden included) + guard + round.
    localparam int          c_div_steps   = 26;

    // Divider FSM state encodings.
    localparam logic [1:0]  c_st_idle     = 2'd0;
    localparam logic [1:0]  c_st_divide   = 2'd1;
    localparam logic [1:0]  c_st_round    = 2'd2;

    // Denormals carry exponent 0 and are treated as signed zero.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == '1) && (x[22:0] == '0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == '1) && (x[22:0] != '0);
    endfunction

endpackage : fp32_div_pkg
`default_nettype wire

// File: rtl/fp32_div_mant.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_div_mant
//  Description : 26-step restoring radix-2 mantissa divider, one quotient bit
//                per clock.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_start     - load operands and begin a division
//                i_ma        - pre-normalised dividend mantissa (mb <= ma < 2*mb)
//                i_mb        - divisor mantissa {1, frac}
//                o_q         - quotient bits, o_q[25] is the integer bit
//                o_sticky    - non-zero final remainder
//                o_done      - high during the cycle of the last iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_mant
    import fp32_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [24:0] i_ma,
    input  logic [23:0] i_mb,
    output logic [25:0] o_q,
    output logic        o_sticky,
    output logic        o_done
);

    localparam logic [4:0] c_last_step = 5'(c_div_steps - 1);

    logic [24:0] r_rem;
    logic [23:0] r_mb;
    logic [25:0] r_q;
    logic [4:0]  r_count;
    logic        r_busy;

    logic        w_ge;
    logic [24:0] w_rem_next;

    // The remainder always stays below mb after the compare/subtract, so the
    // left shift never loses a significant bit.
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_rem_next = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_mb    <= '0;
            r_q     <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_rem   <= i_ma;
            r_mb    <= i_mb;
            r_q     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_rem   <= w_rem_next << 1;
            r_q     <= {r_q[24:0], w_ge};
            r_count <= r_count + 5'd1;
            if (r_count == c_last_step) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_q      = r_q;
    assign o_sticky = (r_rem != '0);
    // Lets the controller leave its divide state on the final iteration edge.
    assign o_done   = r_busy && (r_count == c_last_step);

endmodule : fp32_div_mant
`default_nettype wire

// File: rtl/fp32_div.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_div
//  Description : Iterative IEEE-754 single-precision divider c = a / b with
//                round-to-nearest-even and a fixed 27-cycle latency.
//  Ports       : clk_in     - system clock
//                rst_in     - synchronous active-high reset
//                valid_in   - operand pair present (taken when ready_out=1)
//                a_in, b_in - dividend / divisor, fp32
//                ready_out  - block idle and able to accept
//                valid_out  - one-cycle pulse marking c_out valid
//                c_out      - quotient, fp32, held until the next result
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_div
    import fp32_div_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [31:0] c_out
);

    logic [1:0]         r_state;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic               r_special;
    logic [31:0]        r_special_val;
    logic               r_ready;
    logic               r_valid;
    logic [31:0]        r_c;

    logic               w_accept;
    logic [23:0]        w_ma;
    logic [23:0]        w_mb;
    logic               w_adj;
    logic [24:0]        w_ma_norm;
    logic signed [9:0]  w_exp_acc;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_special_val;

    logic [25:0]        w_q;
    logic               w_sticky;
    logic               w_done;

    logic [24:0]        w_sum;
    logic               w_inc;
    logic signed [9:0]  w_exp_rnd;
    logic [31:0]        w_result;

    assign w_accept = (r_state == c_st_idle) && valid_in;

    // ---------------- accept-edge operand preparation ----------------
    always_comb begin
        w_sign    = a_in[31] ^ b_in[31];
        w_ma      = {1'b1, a_in[c_fp32_frac_w-1:0]};
        w_mb      = {1'b1, b_in[c_fp32_frac_w-1:0]};
        // Pre-shift so the quotient lies in [1,2) and q[25] is always set.
        w_adj     = (w_ma < w_mb);
        w_ma_norm = w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
        w_exp_acc = {2'b00, a_in[30:23]} - {2'b00, b_in[30:23]}
                  + {2'b00, c_fp32_bias} - {9'd0, w_adj};
    end

    // Special cases are fully resolved here; the divider still runs so the
    // latency is identical for every operand pair.
    always_comb begin
        w_special     = 1'b1;
        w_special_val = c_fp32_nan;
        if (is_nan(a_in) || is_nan(b_in)) begin
            w_special_val = c_fp32_nan;
        end else if (is_zero(a_in) && is_zero(b_in)) begin
            w_special_val = c_fp32_nan;
        end else if (is_inf(a_in) && is_inf(b_in)) begin
            w_special_val = c_fp32_nan;
        end else if (is_zero(b_in) || is_inf(a_in)) begin
            w_special_val = w_sign ? c_fp32_ninf : c_fp32_pinf;
        end else if (is_inf(b_in) || is_zero(a_in)) begin
            w_special_val = {w_sign, 31'd0};
        end else begin
            w_special     = 1'b0;
        end
    end

    fp32_div_mant u_mant (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_start  (w_accept),
        .i_ma     (w_ma_norm),
        .i_mb     (w_mb),
        .o_q      (w_q),
        .o_sticky (w_sticky),
        .o_done   (w_done)
    );

    // ---------------- rounding (RNE) and range handling ----------------
    always_comb begin
        w_inc     = w_q[1] & (w_q[0] | w_sticky | w_q[2]);
        w_sum     = {1'b0, w_q[25:2]} + {24'd0, w_inc};
        // On mantissa carry-out the fraction bits are already zero.
        w_exp_rnd = r_exp + $signed({9'd0, w_sum[24]});
        if (r_special) begin
            w_result = r_special_val;
        end else if (w_exp_rnd >= 10'sd255) begin
            w_result = r_sign ? c_fp32_ninf : c_fp32_pinf;
        end else if (w_exp_rnd <= 10'sd0) begin
            w_result = {r_sign, 31'd0};
        end else begin
            w_result = {r_sign, w_exp_rnd[c_fp32_exp_w-1:0], w_sum[c_fp32_frac_w-1:0]};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= c_st_idle;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_ready       <= 1'b1;
            r_valid       <= 1'b0;
            r_c           <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (valid_in) begin
                        r_sign        <= w_sign;
                        r_exp         <= w_exp_acc;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
                        r_ready       <= 1'b0;
                        r_state       <= c_st_divide;
                    end
                end
                c_st_divide: begin
                    if (w_done) begin
                        r_state <= c_st_round;
                    end
                end
                c_st_round: begin
                    r_c     <= w_result;
                    r_valid <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ready_out = r_ready;
    assign valid_out = r_valid;
    assign c_out     = r_c;

endmodule : fp32_div
`default_nettype wire
